// File: rtl/ysyx_22051013_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22051013_mem_responder
// Description : Memory-side responder for the LSU load/store port. Accepts
//               one read or byte-masked write at a time, services it from an
//               internal 64-bit-wide array and answers after a fixed latency
//               on a valid/ready response channel.
//               Optional macro YSYX_22051013_MEM_RANGE_CHK_EN enables
//               address range checking (error response, write suppression).
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22051013_mem_responder #(
   parameter int          DEPTH_LOG2 = 12,
   parameter logic [63:0] BASE_ADDR  = 64'h8000_0000,
   parameter int          LATENCY    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   input  logic [7:0]  req_wstrb,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int         c_DEPTH    = 1 << DEPTH_LOG2;
   // Countdown preload; the WAIT state spends c_CNT_INIT+1 cycles so that
   // rsp_valid is first seen high LATENCY edges after the accept edge.
   localparam logic [3:0] c_CNT_INIT = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [3:0]              r_cnt;
   logic [3:0]              w_cnt_nxt;
   logic [63:0]             r_mem [0:c_DEPTH-1];
   logic [63:0]             r_rdata;
   logic                    r_err;

   logic                    w_accept;
   logic [63:0]             w_off;
   logic [DEPTH_LOG2-1:0]   w_idx;
   logic                    w_in_range;
   logic                    w_wr_en;

   // Byte offset from the array base; the word index is taken from it so an
   // address below BASE_ADDR wraps into the top of the array.
   assign w_off = req_addr - BASE_ADDR;
   assign w_idx = w_off[DEPTH_LOG2+2:3];

`ifdef YSYX_22051013_MEM_RANGE_CHK_EN
   localparam logic [63:0] c_SPAN = 64'(1) << (DEPTH_LOG2 + 3);
   // Unsigned compare: addresses below the base wrap to huge offsets.
   assign w_in_range = (w_off < c_SPAN);
`else
   logic w_unused;
   assign w_in_range = 1'b1;
   assign w_unused   = ^{w_off[63:DEPTH_LOG2+3], w_off[2:0]};
`endif

   // Ready only in IDLE and never while reset is asserted.
   assign req_ready = (r_state == ST_IDLE) && !rst;
   assign w_accept  = req_valid && req_ready;
   assign w_wr_en   = w_accept && req_we && w_in_range;

   assign rsp_valid = (r_state == ST_RESP);
   assign rsp_rdata = r_rdata;
   assign rsp_err   = r_err;

   // Storage array: byte-lane write at the accept edge, never cleared by reset.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         for (int n = 0; n < 8; n++) begin
            if (req_wstrb[n]) begin
               r_mem[w_idx][8*n +: 8] <= req_wdata[8*n +: 8];
            end
         end
      end
   end

   // State, countdown and response registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= 4'd0;
         r_rdata <= 64'd0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_accept) begin
            r_rdata <= (!req_we && w_in_range) ? r_mem[w_idx] : 64'd0;
            r_err   <= !w_in_range;
         end
      end
   end

   // Next-state logic: accept -> count down latency -> hold response.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_state_nxt = ST_WAIT;
               w_cnt_nxt   = c_CNT_INIT;
            end
         end
         ST_WAIT: begin
            if (r_cnt == 4'd0) begin
               w_state_nxt = ST_RESP;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22051013_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_22051013_mem_responder
// Description : Directed self-checking bench for ysyx_22051013_mem_responder
//               (default parameters: LATENCY 2, 4096 words at 0x8000_0000).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_22051013_mem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic [7:0]  req_wstrb;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [63:0] rsp_rdata;
   logic        rsp_err;

   int checks = 0;
   int errors = 0;

   ysyx_22051013_mem_responder dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_wstrb (req_wstrb),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One complete transaction with rsp_ready held high; called #1 after an edge.
   task automatic do_txn(input string tag, input logic we, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [7:0] strb,
                         input logic [63:0] exp_data, input logic [63:0] mask,
                         input logic exp_err);
      int lat;
      lat = 0;
      chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      req_wstrb = strb;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_wdata = 64'd0;
      req_wstrb = 8'd0;
      while (rsp_valid !== 1'b1 && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk({tag, "_latency"}, 64'(lat), 64'd2);
      chk({tag, "_rdata"}, rsp_rdata & mask, exp_data & mask);
      chk({tag, "_err"}, 64'(rsp_err), 64'(exp_err));
      @(posedge clk);
      #1;
      chk({tag, "_rsp_done"}, 64'(rsp_valid), 64'd0);
   endtask

   initial begin
      logic [63:0] held;
      rst       = 1'b1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = 64'd0;
      req_wdata = 64'd0;
      req_wstrb = 8'd0;
      rsp_ready = 1'b1;

      // Reset for three cycles; ready must stay low while rst is high.
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_req_ready", 64'(req_ready), 64'd1);
      chk("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("post_rst_rsp_rdata", rsp_rdata, 64'd0);
      chk("post_rst_rsp_err", 64'(rsp_err), 64'd0);
      @(posedge clk);
      #1;

      // Full write, then read through an unaligned address of the same word.
      do_txn("wr_full", 1'b1, 64'h8000_0008, 64'h1122_3344_5566_7788, 8'hFF,
             64'd0, '1, 1'b0);
      do_txn("rd_full", 1'b0, 64'h8000_000D, 64'd0, 8'h00,
             64'h1122_3344_5566_7788, '1, 1'b0);

      // Partial write of lanes 2 and 3, read back merged word.
      do_txn("wr_part", 1'b1, 64'h8000_0008, 64'hAAAA_BBBB_CCCC_DDDD, 8'h0C,
             64'd0, '1, 1'b0);
      do_txn("rd_merge", 1'b0, 64'h8000_0008, 64'd0, 8'h00,
             64'h1122_3344_CCCC_7788, '1, 1'b0);

      // Zero-strobe write leaves the word untouched.
      do_txn("wr_nostrb", 1'b1, 64'h8000_0008, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00,
             64'd0, '1, 1'b0);
      do_txn("rd_nostrb", 1'b0, 64'h8000_0008, 64'd0, 8'h00,
             64'h1122_3344_CCCC_7788, '1, 1'b0);

      // Backpressure: response held 10 cycles; a competing write must not be taken.
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 64'h8000_0008;
      @(posedge clk);
      #1;
      req_we    = 1'b1;
      req_wdata = 64'd0;
      req_wstrb = 8'hFF;
      repeat (2) @(posedge clk);
      #1;
      chk("bp_valid_first", 64'(rsp_valid), 64'd1);
      held = rsp_rdata;
      chk("bp_rdata_first", held, 64'h1122_3344_CCCC_7788);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         chk("bp_valid_hold", 64'(rsp_valid), 64'd1);
         chk("bp_rdata_hold", rsp_rdata, 64'h1122_3344_CCCC_7788);
         chk("bp_req_ready", 64'(req_ready), 64'd0);
      end
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_wstrb = 8'h00;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_release_valid", 64'(rsp_valid), 64'd0);
      chk("bp_release_ready", 64'(req_ready), 64'd1);
      do_txn("bp_no_write", 1'b0, 64'h8000_0008, 64'd0, 8'h00,
             64'h1122_3344_CCCC_7788, '1, 1'b0);

      // Address below the base: error response or alias of the last word.
`ifdef YSYX_22051013_MEM_RANGE_CHK_EN
      do_txn("wr_top", 1'b1, 64'h8000_7FF8, 64'h0123_4567_89AB_CDEF, 8'hFF,
             64'd0, '1, 1'b0);
      do_txn("wr_oor", 1'b1, 64'h7FFF_FFF8, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF,
             64'd0, '1, 1'b1);
      do_txn("rd_oor_hi", 1'b0, 64'h8000_8000, 64'd0, 8'h00,
             64'd0, '1, 1'b1);
      do_txn("rd_top", 1'b0, 64'h8000_7FF8, 64'd0, 8'h00,
             64'h0123_4567_89AB_CDEF, '1, 1'b0);
`else
      do_txn("wr_alias", 1'b1, 64'h7FFF_FFF8, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF,
             64'd0, '1, 1'b0);
      do_txn("rd_alias", 1'b0, 64'h8000_7FF8, 64'd0, 8'h00,
             64'hDEAD_BEEF_CAFE_F00D, '1, 1'b0);
`endif

      // Reset during WAIT after a single-byte write: no response, write kept.
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 64'h8000_0000;
      req_wdata = 64'h0000_0000_0000_005A;
      req_wstrb = 8'h01;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_wstrb = 8'h00;
      chk("abort_pre_valid", 64'(rsp_valid), 64'd0);
      rst = 1'b1;
      #1;
      chk("abort_rst_valid", 64'(rsp_valid), 64'd0);
      chk("abort_rst_ready", 64'(req_ready), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("abort_hold_valid", 64'(rsp_valid), 64'd0);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("abort_after_valid", 64'(rsp_valid), 64'd0);
      do_txn("rd_after_abort", 1'b0, 64'h8000_0000, 64'd0, 8'h00,
             64'h0000_0000_0000_005A, 64'h0000_0000_0000_00FF, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
